// File: rtl/led_blink_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_ctrl
//  Description : Prescaled LED pattern generator. A programmable divider
//                produces a periodic tick; on each tick the LED bank is
//                updated according to the selected mode (OFF, ON, BLINK,
//                CHASE). A mode change reloads the mode's entry pattern and
//                restarts the prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_blink_ctrl #(
    parameter int               CNT_W    = 8,
    parameter int               CH_NUM   = 4,
    parameter logic [CNT_W-1:0] DIV_INIT = {CNT_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              div_wr,
    input  logic [CNT_W-1:0]  div_val,
    output logic [CH_NUM-1:0] led,
    output logic              tick,
    output logic [CNT_W-1:0]  step
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_BLINK = 2'd2,
        ST_CHASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CH_NUM-1:0] c_led_zeros = {CH_NUM{1'b0}};
    localparam logic [CH_NUM-1:0] c_led_ones  = {CH_NUM{1'b1}};
    localparam logic [CH_NUM-1:0] c_led_first = {{(CH_NUM-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_mode_q;
    logic [CNT_W-1:0]    r_div;
    logic [CNT_W-1:0]    r_pre_cnt;
    logic [CNT_W-1:0]    r_step;
    logic [CH_NUM-1:0]   r_led;
    logic                r_tick;

    logic                w_mode_chg;
    logic                w_wrap;
    logic [CH_NUM-1:0]   w_led_entry;
    logic [CH_NUM-1:0]   w_led_tick;

    assign w_mode_chg = (mode != r_mode_q);
    assign w_wrap     = en && (r_pre_cnt == r_div);

    // State register: tracks the mode in force, plus the raw registered mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_OFF;
            r_mode_q <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode_q <= mode;
        end
    end

    // Next state follows mode; entry pattern for the incoming mode and the
    // per-tick update pattern for the current one
    always_comb begin
        w_state_nxt = state_t'(mode);
        w_led_entry = c_led_zeros;
        w_led_tick  = r_led;
        case (state_t'(mode))
            ST_OFF:   w_led_entry = c_led_zeros;
            ST_ON:    w_led_entry = c_led_ones;
            ST_BLINK: w_led_entry = c_led_ones;
            ST_CHASE: w_led_entry = c_led_first;
            default:  w_led_entry = c_led_zeros;
        endcase
        case (r_state)
            ST_BLINK: w_led_tick = ~r_led;
            ST_CHASE: w_led_tick = {r_led[CH_NUM-2:0], r_led[CH_NUM-1]};
            default:  w_led_tick = r_led;
        endcase
    end

    // Divider register: written by the strobe regardless of enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= DIV_INIT;
        end else if (div_wr) begin
            r_div <= div_val;
        end
    end

    // Prescaler, tick, step and LED datapath; a mode change outranks a
    // divider write, which outranks a coincident wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= {CNT_W{1'b0}};
            r_step    <= {CNT_W{1'b0}};
            r_led     <= c_led_zeros;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_mode_chg) begin
                r_led     <= w_led_entry;
                r_pre_cnt <= {CNT_W{1'b0}};
            end else if (div_wr) begin
                // Clearing here keeps a smaller new divisor from being overrun
                r_pre_cnt <= {CNT_W{1'b0}};
            end else if (w_wrap) begin
                r_pre_cnt <= {CNT_W{1'b0}};
                r_tick    <= 1'b1;
                r_step    <= r_step + c_cnt_one;
                r_led     <= w_led_tick;
            end else if (en) begin
                r_pre_cnt <= r_pre_cnt + c_cnt_one;
            end
        end
    end

    assign led  = r_led;
    assign tick = r_tick;
    assign step = r_step;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_blink_ctrl
//  Description : Self-checking bench for led_blink_ctrl (CNT_W=8, CH_NUM=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       div_wr;
    logic [7:0] div_val;
    logic [3:0] led;
    logic       tick;
    logic [7:0] step;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [3:0] led;
        logic       tick;
        logic [7:0] step;
    } exp_t;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       wr;
        logic [7:0] val;
        logic [3:0] led;
        logic       tick;
        logic [7:0] step;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[13];

    led_blink_ctrl #(.CNT_W(8), .CH_NUM(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .div_wr  (div_wr),
        .div_val (div_val),
        .led     (led),
        .tick    (tick),
        .step    (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Drive one cycle of inputs, queue its expected result, compare after the edge
    task automatic cyc(input logic e, input logic [1:0] m, input logic w, input logic [7:0] v,
                       input logic [3:0] xl, input logic xt, input logic [7:0] xs, input string name);
        exp_t x;
        exp_t got;
        @(negedge clk);
        en = e; mode = m; div_wr = w; div_val = v;
        x.led = xl; x.tick = xt; x.step = xs;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({name, ".led"},  32'(led),  32'(got.led));
        chk({name, ".tick"}, 32'(tick), 32'(got.tick));
        chk({name, ".step"}, 32'(step), 32'(got.step));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Blink: div 3, entry 1111, toggle every 4 cycles with tick and step
        tbl[0]  = '{1'b1, 2'd2, 1'b1, 8'd3, 4'hF, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 2'd2, 1'b0, 8'd0, 4'hF, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 8'd0, 4'hF, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 2'd2, 1'b0, 8'd0, 4'hF, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 2'd2, 1'b0, 8'd0, 4'h0, 1'b1, 8'd1};
        tbl[5]  = '{1'b1, 2'd2, 1'b0, 8'd0, 4'h0, 1'b0, 8'd1};
        tbl[6]  = '{1'b1, 2'd2, 1'b0, 8'd0, 4'h0, 1'b0, 8'd1};
        tbl[7]  = '{1'b1, 2'd2, 1'b0, 8'd0, 4'h0, 1'b0, 8'd1};
        tbl[8]  = '{1'b1, 2'd2, 1'b0, 8'd0, 4'hF, 1'b1, 8'd2};
        tbl[9]  = '{1'b1, 2'd2, 1'b0, 8'd0, 4'hF, 1'b0, 8'd2};
        tbl[10] = '{1'b1, 2'd2, 1'b0, 8'd0, 4'hF, 1'b0, 8'd2};
        tbl[11] = '{1'b1, 2'd2, 1'b0, 8'd0, 4'hF, 1'b0, 8'd2};
        tbl[12] = '{1'b1, 2'd2, 1'b0, 8'd0, 4'h0, 1'b1, 8'd3};

        rst_n = 1'b0; en = 1'b0; mode = 2'd0; div_wr = 1'b0; div_val = 8'd0;
        #12;
        chk("reset.led",  32'(led),  32'd0);
        chk("reset.tick", 32'(tick), 32'd0);
        chk("reset.step", 32'(step), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            cyc(tbl[i].en, tbl[i].mode, tbl[i].wr, tbl[i].val,
                tbl[i].led, tbl[i].tick, tbl[i].step, $sformatf("blink[%0d]", i));

        // Enable hold at pre_cnt=2, then tick exactly 2 cycles after resume
        cyc(1'b1, 2'd2, 1'b0, 8'd0, 4'h0, 1'b0, 8'd3, "hold.pre1");
        cyc(1'b1, 2'd2, 1'b0, 8'd0, 4'h0, 1'b0, 8'd3, "hold.pre2");
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 2'd2, 1'b0, 8'd0, 4'h0, 1'b0, 8'd3, $sformatf("hold.off[%0d]", i));
        cyc(1'b1, 2'd2, 1'b0, 8'd0, 4'h0, 1'b0, 8'd3, "hold.resume1");
        cyc(1'b1, 2'd2, 1'b0, 8'd0, 4'hF, 1'b1, 8'd4, "hold.resume2");

        // Asynchronous reset between edges while BLINK shows 1111 with tick high
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst.led",  32'(led),  32'd0);
        chk("async_rst.tick", 32'(tick), 32'd0);
        chk("async_rst.step", 32'(step), 32'd0);
        @(negedge clk);
        en = 1'b1; mode = 2'd2; div_wr = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_held.led", 32'(led), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous mode change and divider write at the wrap point
        cyc(1'b1, 2'd2, 1'b1, 8'd3, 4'hF, 1'b0, 8'd0, "simul.entry");
        cyc(1'b1, 2'd2, 1'b0, 8'd0, 4'hF, 1'b0, 8'd0, "simul.pre1");
        cyc(1'b1, 2'd2, 1'b0, 8'd0, 4'hF, 1'b0, 8'd0, "simul.pre2");
        cyc(1'b1, 2'd2, 1'b0, 8'd0, 4'hF, 1'b0, 8'd0, "simul.pre3");
        cyc(1'b1, 2'd3, 1'b1, 8'd5, 4'h1, 1'b0, 8'd0, "simul.edge");
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 2'd3, 1'b0, 8'd0, 4'h1, 1'b0, 8'd0, $sformatf("simul.cnt[%0d]", i));
        cyc(1'b1, 2'd3, 1'b0, 8'd0, 4'h2, 1'b1, 8'd1, "simul.tick");

        // Chase at div 0: rotate every cycle with tick held high
        cyc(1'b1, 2'd1, 1'b1, 8'd0, 4'hF, 1'b0, 8'd1, "chase.via_on");
        cyc(1'b1, 2'd3, 1'b0, 8'd0, 4'h1, 1'b0, 8'd1, "chase.entry");
        cyc(1'b1, 2'd3, 1'b0, 8'd0, 4'h2, 1'b1, 8'd2, "chase.s1");
        cyc(1'b1, 2'd3, 1'b0, 8'd0, 4'h4, 1'b1, 8'd3, "chase.s2");
        cyc(1'b1, 2'd3, 1'b0, 8'd0, 4'h8, 1'b1, 8'd4, "chase.s3");
        cyc(1'b1, 2'd3, 1'b0, 8'd0, 4'h1, 1'b1, 8'd5, "chase.wrap");
        cyc(1'b1, 2'd3, 1'b0, 8'd0, 4'h2, 1'b1, 8'd6, "chase.s5");

        // ON with div 0: 256 ticks, step wraps 255 -> 0, led stays 1111
        cyc(1'b1, 2'd1, 1'b0, 8'd0, 4'hF, 1'b0, 8'd6, "on.entry");
        for (int k = 1; k <= 256; k++)
            cyc(1'b1, 2'd1, 1'b0, 8'd0, 4'hF, 1'b1, 8'((6 + k) % 256), $sformatf("on.step[%0d]", k));

        // OFF entry clears the LEDs and holds step
        cyc(1'b1, 2'd0, 1'b0, 8'd0, 4'h0, 1'b0, 8'd6, "off.entry");
        cyc(1'b1, 2'd0, 1'b0, 8'd0, 4'h0, 1'b1, 8'd7, "off.tick");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_blink_ctrl.md
LED_BLINK_CTRL -- requirements
Module: led_blink_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the divider, prescaler and step counter (legal range 2..32).
REQ-002 The block SHALL have parameter CH_NUM, default 4, giving the number of LED channels (legal range 2..32).
REQ-003 The block SHALL have parameter DIV_INIT, default all ones of CNT_W bits, giving the divider reset value.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  count enable; when low, the prescaler, tick, step and led states hold.
REQ-007 mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=CHASE.
REQ-008 div_wr  input  1  single-cycle strobe that loads div_val into the divider register.
REQ-009 div_val  input  CNT_W  new divider value.
REQ-010 led  output  CH_NUM  registered LED drive.
REQ-011 tick  output  1  registered one-cycle pulse at each prescaler wrap.
REQ-012 step  output  CNT_W  registered tick count, modulo 2^CNT_W.

Function
REQ-013 div_reg SHALL load div_val on the edge where div_wr=1; the same edge SHALL clear pre_cnt to 0 and drive tick to 0.
REQ-014 With en=1 and pre_cnt!=div_reg, pre_cnt SHALL increment by 1 per cycle.
REQ-015 With en=1 and pre_cnt==div_reg, the edge SHALL set pre_cnt to 0 and tick to 1 (one cycle wide), increment step, and apply the mode update to led; tick period SHALL be div_reg+1 cycles.
REQ-016 div_reg=0 SHALL give tick=1 on every enabled cycle.
REQ-017 On every edge not covered by REQ-015, tick SHALL be 0.
REQ-018 step SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-019 With en=0, pre_cnt, step and led SHALL hold and tick SHALL be 0; div_wr and mode changes SHALL still take effect.
REQ-020 The state machine SHALL have states OFF, ON, BLINK and CHASE, selected by mode; mode_q SHALL register mode every cycle.
REQ-021 Mode change (mode!=mode_q) SHALL, on that edge:
- load the entry value into led;
- clear pre_cnt;
- force tick to 0 and suppress the step increment.
REQ-022 Entry values SHALL be: OFF -> all zeros; ON -> all ones; BLINK -> all ones; CHASE -> 1 (bit 0 only).
REQ-023 On a tick, OFF and ON SHALL leave led unchanged; BLINK SHALL invert all bits; CHASE SHALL rotate led left by one, with bit CH_NUM-1 wrapping to bit 0.
REQ-024 A mode change and div_wr on the same edge SHALL both apply; pre_cnt becomes 0 and tick becomes 0.
REQ-025 A mode change SHALL take priority over a coincident prescaler wrap: the entry value is loaded and no tick occurs.
REQ-026 Loading div_val smaller than the current pre_cnt SHALL NOT cause a counter overrun, because pre_cnt is cleared by REQ-013.

Reset
REQ-027 rst_n=0 SHALL immediately, with no clock edge, force:
- led=0, tick=0, step=0;
- pre_cnt=0, div_reg=DIV_INIT;
- mode_q=0 and state OFF.
REQ-028 Reset asserted mid-operation SHALL abort the current count with no residual tick.
REQ-029 After rst_n rises, a mode input that is not 0 SHALL be treated as a mode change on the first edge.

Verification (CNT_W=8, CH_NUM=4)
REQ-030 Reset check: BLINK running with led=1111, rst_n low between clock edges -> led=0000, tick=0, step=0, before the next edge.
REQ-031 Blink check: div_wr with div_val=3, mode=2, en=1 -> led=1111, then toggles every 4 cycles; tick=1 on each toggle cycle; step increments 1,2,3...
REQ-032 Chase check: div_val=0, mode=3, en=1 -> led=0001,0010,0100,1000,0001 on consecutive cycles; tick held high.
REQ-033 Step wrap check: div_val=0, mode=1, 256 enabled cycles after entry -> step goes 255->0; led stays 1111.
REQ-034 Enable hold check: BLINK, div_val=3, en low for 10 cycles at pre_cnt=2 -> no tick, led and step frozen; after en returns high, next tick after exactly 2 cycles.
REQ-035 Simultaneous update check: at pre_cnt==div_reg, mode 2->3 with div_wr div_val=5 on the same edge -> led=0001, tick=0, step unchanged; first tick 6 cycles later.
